renode_reset_sequencer: RTL
===========================

Name: renode_reset_sequencer

Overview:
- Parametrised reset sequencer between the Renode bus_connection reset handshake and NumPorts AXI managers (e.g. Snitch cluster wrappers).
- Extends the fixed two-cycle handshake with:
  - per-port selectable reset;
  - a drain phase that gates new AW/AR and waits for outstanding AXI transactions to complete;
  - configurable assert/deassert hold times;
  - a drain timeout.
- Sits between the top-level testbench glue and the manager instances, driving their active-low resets.

Parameters:
- NumPorts, 1, number of AXI managers sequenced.
- AssertCycles, 2, cycles reset is held before assert_ack_o; must be >=1.
- DeassertCycles, 2, cycles reset stays asserted after a deassert request before release; must be >=1.
- MaxOutstanding, 16, per-port per-direction outstanding-transaction limit; sets counter width $clog2(MaxOutstanding+1).
- DrainTimeout, 1024, drain cycles before forced reset; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- assert_req_i  in  1  level request; held until assert_ack_o
- assert_ack_o  out  1  one-cycle acknowledge pulse
- deassert_req_i  in  1  level request; held until deassert_ack_o
- deassert_ack_o  out  1  one-cycle acknowledge pulse
- port_mask_i  in  NumPorts  ports affected by the next assert request
- aw_hs_i  in  NumPorts  AW valid&ready per port
- b_hs_i  in  NumPorts  B valid&ready per port
- ar_hs_i  in  NumPorts  AR valid&ready per port
- r_last_hs_i  in  NumPorts  R valid&ready&last per port
- gate_o  out  NumPorts  block new AW/AR issue (force aw_valid/ar_valid low)
- mgr_rst_no  out  NumPorts  active-low manager reset
- busy_o  out  1  state is not RUN and not IN_RESET
- timeout_o  out  1  sticky: last drain was forced by timeout
- overflow_o  out  1  sticky: an outstanding counter saturated

Behaviour:
- Reset values (rst_i high, asynchronous):
  - state IN_RESET; mgr_rst_no all 0; gate_o all 1.
  - Acks 0; busy_o 0; timeout_o 0; overflow_o 0.
  - Counters 0; latched mask all 1.
- After reset, managers stay in reset until a deassert request completes.
- Counters: one write and one read counter per port.
  - Write counter: +1 on aw_hs, -1 on b_hs; both in the same cycle means unchanged.
  - Read counter: same rule with ar_hs / r_last_hs.
  - Increment at MaxOutstanding saturates and sets overflow_o.
  - Decrement at 0 holds at 0.
  - Counters of a port clear while its mgr_rst_no is 0.
- Requests: if both are high in RUN or IN_RESET, assert wins; deassert stays pending.
- States and transitions:
  - RUN, assert_req: latch port_mask_i -> DRAIN; gate_o[i]=1 for masked ports.
  - RUN, deassert_req: ack pulse next cycle, no other effect.
  - DRAIN: when all masked counters are 0 -> ASSERT. If DrainTimeout!=0 and the drain cycle count reaches DrainTimeout -> ASSERT and set timeout_o.
  - ASSERT: mgr_rst_no[i]=0 for masked ports from entry; count AssertCycles cycles -> IN_RESET with assert_ack_o pulse on the entry cycle.
  - IN_RESET, assert_req: ack pulse next cycle (idempotent); mask unchanged.
  - IN_RESET, deassert_req -> RELEASE; reset still held.
  - RELEASE: count DeassertCycles cycles -> RUN. On entry to RUN: mgr_rst_no[i]=1 and gate_o[i]=0 for latched ports, deassert_ack_o pulses that cycle, timeout_o clears.
- Unmasked ports keep their mgr_rst_no/gate_o values throughout a sequence.
- Latency (defaults, nothing outstanding):
  - assert_req first high in cycle 0 -> mgr_rst_no low from cycle 2, assert_ack_o in cycle 4.
  - deassert_req in cycle 0 -> release and deassert_ack_o in cycle 3.
- Requester drops req the cycle after the ack; a req still high then is treated as a new request.
- rst_i mid-sequence: immediate return to the reset values above, regardless of state.

Decomposition:
- Package renode_rst_seq_pkg holds:
  - state enum (RUN, DRAIN, ASSERT, IN_RESET, RELEASE);
  - counter width function;
  - default hold-cycle constants.
- Sub-module renode_outstanding_counter: one up/down saturating counter with overflow flag, instantiated 2*NumPorts times.

Test Plan:
- Power-on: rst_i pulse, then deassert_req in cycle 0 -> mgr_rst_no all 0 until cycle 3; cycle 3 mgr_rst_no=all 1, deassert_ack_o=1 for exactly 1 cycle.
- Drain (NumPorts=2, mask=2'b01):
  - Setup: port0 has 3 AW accepted; assert_req in cycle 0.
  - gate_o=2'b01 from cycle 1; B handshakes in cycles 5, 6, 7.
  - mgr_rst_no[0]=0 from cycle 9; ack in cycle 11; port1 untouched.
- Timeout (DrainTimeout=8): 1 AR outstanding, no R -> reset asserted after 8 drain cycles, timeout_o=1, cleared by the next deassert ack.
- Simultaneous aw_hs and b_hs every cycle for 20 cycles -> counter constant. 17 AW with no B (MaxOutstanding=16) -> count 16, overflow_o=1.
- Both reqs high in RUN -> assert sequence first; deassert acked after assert_ack. assert_req in IN_RESET -> ack next cycle, no state change.
- rst_i asserted while in DRAIN -> same cycle asynchronously: gate_o all 1, mgr_rst_no all 0, state IN_RESET, busy_o 0.

Source files
------------

// File: rtl/renode_rst_seq_pkg.sv
// Shared types and constants for the Renode reset sequencer: sequencer states,
// outstanding-counter sizing and default hold times.
package renode_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_ASSERT   = 3'd2,
    ST_IN_RESET = 3'd3,
    ST_RELEASE  = 3'd4
  } seq_state_e;

  localparam int unsigned DefAssertCycles   = 32'd2;
  localparam int unsigned DefDeassertCycles = 32'd2;
  localparam int unsigned DefMaxOutstanding = 32'd16;
  localparam int unsigned DefDrainTimeout   = 32'd1024;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 32'd1) ? 32'd1 : $clog2(max_val + 32'd1);
  endfunction

endpackage

// File: rtl/renode_outstanding_counter.sv
// Up/down outstanding-transaction counter: saturates at MaxOutstanding (flagging
// the lost increment on ovf_o), holds at zero, and clears while clr_i is high.
module renode_outstanding_counter
  import renode_rst_seq_pkg::*;
#(
  parameter int unsigned MaxOutstanding = DefMaxOutstanding,
  parameter int unsigned CntW           = cnt_width(MaxOutstanding)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o,
  output logic            ovf_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [CntW-1:0] cnt_r;
  logic [CntW-1:0] cnt_next_s;
  logic            ovf_s;

  // Next count: simultaneous inc and dec cancel out.
  always_comb begin
    cnt_next_s = cnt_r;
    ovf_s      = 1'b0;
    if (clr_i) begin
      cnt_next_s = '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_r == CntMax) begin
        ovf_s = 1'b1;
      end else begin
        cnt_next_s = cnt_r + CntW'(1);
      end
    end else if (dec_i && !inc_i) begin
      if (cnt_r != '0) begin
        cnt_next_s = cnt_r - CntW'(1);
      end else begin
        cnt_next_s = '0;
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign cnt_o = cnt_r;
  assign ovf_o = ovf_s;

endmodule

// File: rtl/renode_reset_sequencer.sv
// Reset sequencer between the Renode reset handshake and NumPorts AXI managers:
// gates and drains selected ports, then holds/releases their active-low resets.
module renode_reset_sequencer
  import renode_rst_seq_pkg::*;
#(
  parameter int unsigned NumPorts       = 32'd1,
  parameter int unsigned AssertCycles   = DefAssertCycles,
  parameter int unsigned DeassertCycles = DefDeassertCycles,
  parameter int unsigned MaxOutstanding = DefMaxOutstanding,
  parameter int unsigned DrainTimeout   = DefDrainTimeout
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                assert_req_i,
  output logic                assert_ack_o,
  input  logic                deassert_req_i,
  output logic                deassert_ack_o,
  input  logic [NumPorts-1:0] port_mask_i,
  input  logic [NumPorts-1:0] aw_hs_i,
  input  logic [NumPorts-1:0] b_hs_i,
  input  logic [NumPorts-1:0] ar_hs_i,
  input  logic [NumPorts-1:0] r_last_hs_i,
  output logic [NumPorts-1:0] gate_o,
  output logic [NumPorts-1:0] mgr_rst_no,
  output logic                busy_o,
  output logic                timeout_o,
  output logic                overflow_o
);

  localparam int unsigned CntW    = cnt_width(MaxOutstanding);
  localparam int unsigned HoldMax = (AssertCycles > DeassertCycles) ? AssertCycles : DeassertCycles;
  localparam int unsigned HoldW   = cnt_width(HoldMax);
  localparam int unsigned DrainW  = cnt_width(DrainTimeout);
  localparam logic [HoldW-1:0]  AssertLast   = HoldW'(AssertCycles - 32'd1);
  localparam logic [HoldW-1:0]  DeassertLast = HoldW'(DeassertCycles - 32'd1);
  localparam logic [DrainW-1:0] DrainLast    =
    DrainW'((DrainTimeout > 32'd0) ? (DrainTimeout - 32'd1) : 32'd0);

  seq_state_e          state_r, state_next_s;
  logic [NumPorts-1:0] mask_r, mask_next_s;
  logic [NumPorts-1:0] gate_r, gate_next_s;
  logic [NumPorts-1:0] mgr_rst_n_r, mgr_rst_n_next_s;
  logic                assert_ack_r, assert_ack_next_s;
  logic                deassert_ack_r, deassert_ack_next_s;
  logic                timeout_r, timeout_next_s;
  logic                busy_r, busy_next_s;
  logic                overflow_r;
  logic [HoldW-1:0]    hold_r, hold_next_s;
  logic [DrainW-1:0]   drain_r, drain_next_s;

  logic [NumPorts-1:0] wr_nz_s, rd_nz_s, wr_ovf_s, rd_ovf_s;
  logic                drain_done_s;

  for (genvar i = 0; i < NumPorts; i++) begin : g_port
    logic [CntW-1:0] wr_cnt_s, rd_cnt_s;

    renode_outstanding_counter #(
      .MaxOutstanding(MaxOutstanding),
      .CntW          (CntW)
    ) u_wr_cnt (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .clr_i(~mgr_rst_n_r[i]),
      .inc_i(aw_hs_i[i]),
      .dec_i(b_hs_i[i]),
      .cnt_o(wr_cnt_s),
      .ovf_o(wr_ovf_s[i])
    );

    renode_outstanding_counter #(
      .MaxOutstanding(MaxOutstanding),
      .CntW          (CntW)
    ) u_rd_cnt (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .clr_i(~mgr_rst_n_r[i]),
      .inc_i(ar_hs_i[i]),
      .dec_i(r_last_hs_i[i]),
      .cnt_o(rd_cnt_s),
      .ovf_o(rd_ovf_s[i])
    );

    assign wr_nz_s[i] = |wr_cnt_s;
    assign rd_nz_s[i] = |rd_cnt_s;
  end

  assign drain_done_s = ~|(mask_r & (wr_nz_s | rd_nz_s));

  // Next-state and next-output logic; an ack still visible masks the held request.
  always_comb begin
    state_next_s        = state_r;
    mask_next_s         = mask_r;
    gate_next_s         = gate_r;
    mgr_rst_n_next_s    = mgr_rst_n_r;
    assert_ack_next_s   = 1'b0;
    deassert_ack_next_s = 1'b0;
    timeout_next_s      = timeout_r;
    hold_next_s         = hold_r;
    drain_next_s        = drain_r;
    case (state_r)
      ST_RUN: begin
        if (assert_req_i) begin
          state_next_s = ST_DRAIN;
          mask_next_s  = port_mask_i;
          gate_next_s  = gate_r | port_mask_i;
          drain_next_s = '0;
        end else if (deassert_req_i && !deassert_ack_r) begin
          deassert_ack_next_s = 1'b1;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_next_s     = ST_ASSERT;
          mgr_rst_n_next_s = mgr_rst_n_r & ~mask_r;
          hold_next_s      = '0;
        end else if ((DrainTimeout != 32'd0) && (drain_r == DrainLast)) begin
          state_next_s     = ST_ASSERT;
          mgr_rst_n_next_s = mgr_rst_n_r & ~mask_r;
          hold_next_s      = '0;
          timeout_next_s   = 1'b1;
        end else begin
          drain_next_s = drain_r + DrainW'(1);
        end
      end
      ST_ASSERT: begin
        if (hold_r == AssertLast) begin
          state_next_s      = ST_IN_RESET;
          assert_ack_next_s = 1'b1;
        end else begin
          hold_next_s = hold_r + HoldW'(1);
        end
      end
      ST_IN_RESET: begin
        if (assert_req_i && !assert_ack_r) begin
          assert_ack_next_s = 1'b1;
        end else if (deassert_req_i && !deassert_ack_r) begin
          state_next_s = ST_RELEASE;
          hold_next_s  = '0;
        end else begin
          state_next_s = ST_IN_RESET;
        end
      end
      ST_RELEASE: begin
        if (hold_r == DeassertLast) begin
          state_next_s        = ST_RUN;
          mgr_rst_n_next_s    = mgr_rst_n_r | mask_r;
          gate_next_s         = gate_r & ~mask_r;
          deassert_ack_next_s = 1'b1;
          timeout_next_s      = 1'b0;
        end else begin
          hold_next_s = hold_r + HoldW'(1);
        end
      end
      default: begin
        state_next_s     = ST_IN_RESET;
        gate_next_s      = '1;
        mgr_rst_n_next_s = '0;
      end
    endcase
    busy_next_s = (state_next_s != ST_RUN) && (state_next_s != ST_IN_RESET);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r        <= ST_IN_RESET;
      mask_r         <= '1;
      gate_r         <= '1;
      mgr_rst_n_r    <= '0;
      assert_ack_r   <= 1'b0;
      deassert_ack_r <= 1'b0;
      timeout_r      <= 1'b0;
      busy_r         <= 1'b0;
      hold_r         <= '0;
      drain_r        <= '0;
    end else begin
      state_r        <= state_next_s;
      mask_r         <= mask_next_s;
      gate_r         <= gate_next_s;
      mgr_rst_n_r    <= mgr_rst_n_next_s;
      assert_ack_r   <= assert_ack_next_s;
      deassert_ack_r <= deassert_ack_next_s;
      timeout_r      <= timeout_next_s;
      busy_r         <= busy_next_s;
      hold_r         <= hold_next_s;
      drain_r        <= drain_next_s;
    end
  end

  // Sticky record of any lost increment on any counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r | (|wr_ovf_s) | (|rd_ovf_s);
    end
  end

  assign assert_ack_o   = assert_ack_r;
  assign deassert_ack_o = deassert_ack_r;
  assign gate_o         = gate_r;
  assign mgr_rst_no     = mgr_rst_n_r;
  assign busy_o         = busy_r;
  assign timeout_o      = timeout_r;
  assign overflow_o     = overflow_r;

endmodule
